// File: rtl/bss_scanner.sv
// rtl/bss_scanner.sv - time-multiplexed four-digit seven-segment anode scanner
//
// Purpose: holds a 16-bit hex value with per-digit enable and decimal-point
// flags. It steps through the four digit slots at TICKS_PER_DIGIT cycles per
// slot and keeps every anode off for the first GUARD_TICKS cycles of each slot.
// New values are taken in only at frame boundaries.
//
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   value_i      hex value; digit 0 (rightmost) is [3:0]
//   en_i         per-digit enable, 1 = shown
//   dp_i         per-digit decimal point, 1 = lit
//   load_i       capture value_i/en_i/dp_i this cycle
//   nibble_o     nibble of the current digit (to bss_decoder bin_i)
//   anode_o      active-low anode drive
//   dp_o         active-low decimal-point cathode
//   digit_idx_o  current digit slot index
//   frame_o      one-cycle pulse on the last cycle of each frame
module bss_scanner #(
    parameter int TICKS_PER_DIGIT = 100_000,
    parameter int GUARD_TICKS     = 1_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] value_i,
    input  logic [3:0]  en_i,
    input  logic [3:0]  dp_i,
    input  logic        load_i,
    output logic [3:0]  nibble_o,
    output logic [3:0]  anode_o,
    output logic        dp_o,
    output logic [1:0]  digit_idx_o,
    output logic        frame_o
);

    localparam int CW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICKS_PER_DIGIT - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD_TICKS);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;

    logic          pend;
    logic [15:0]   pend_value;
    logic [3:0]    pend_en;
    logic [3:0]    pend_dp;

    logic [15:0]   shadow_value;
    logic [3:0]    shadow_en;
    logic [3:0]    shadow_dp;

    logic          slot_end;
    logic          boundary;
    logic          active;

    assign slot_end = (cnt == CNT_LAST);
    assign boundary = slot_end && (idx == 2'd3);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt          <= '0;
            idx          <= 2'd0;
            pend         <= 1'b0;
            pend_value   <= 16'h0000;
            pend_en      <= 4'b1111;
            pend_dp      <= 4'b0000;
            shadow_value <= 16'h0000;
            shadow_en    <= 4'b1111;
            shadow_dp    <= 4'b0000;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end

            // A load on the boundary cycle goes straight to the shadow set so
            // it still makes the very next frame instead of waiting a whole one.
            if (boundary) begin
                pend <= 1'b0;
                if (load_i) begin
                    shadow_value <= value_i;
                    shadow_en    <= en_i;
                    shadow_dp    <= dp_i;
                end else if (pend) begin
                    shadow_value <= pend_value;
                    shadow_en    <= pend_en;
                    shadow_dp    <= pend_dp;
                end
            end else if (load_i) begin
                pend       <= 1'b1;
                pend_value <= value_i;
                pend_en    <= en_i;
                pend_dp    <= dp_i;
            end
        end
    end

    // Outputs depend only on registered state, so an asynchronous reset
    // blanks the anodes immediately without waiting for a clock edge.
    assign active      = (cnt >= CNT_GUARD) && shadow_en[idx];
    assign anode_o     = active ? ~(4'b0001 << idx) : 4'b1111;
    assign nibble_o    = shadow_value[{idx, 2'b00} +: 4];
    assign dp_o        = active ? ~shadow_dp[idx] : 1'b1;
    assign digit_idx_o = idx;
    assign frame_o     = boundary;

endmodule

// File: tb/tb_bss_scanner.sv
// tb/tb_bss_scanner.sv - directed self-checking bench for bss_scanner
module tb_bss_scanner;

    localparam int T = 8;
    localparam int G = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = 16'h0000;
    logic [3:0]  en = 4'b0000;
    logic [3:0]  dp = 4'b0000;
    logic        load = 1'b0;
    logic [3:0]  nibble;
    logic [3:0]  anode;
    logic        dp_out;
    logic [1:0]  digit_idx;
    logic        frame;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Expected contents of the displayed (shadow) set, set by the test steps.
    logic [15:0] sv;
    logic [3:0]  se;
    logic [3:0]  sd;

    bss_scanner #(
        .TICKS_PER_DIGIT(T),
        .GUARD_TICKS    (G)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .value_i    (value),
        .en_i       (en),
        .dp_i       (dp),
        .load_i     (load),
        .nibble_o   (nibble),
        .anode_o    (anode),
        .dp_o       (dp_out),
        .digit_idx_o(digit_idx),
        .frame_o    (frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk_cycle();
        int c;
        int k;
        int f;
        logic act;
        logic [3:0] ea;
        c = cyc % T;
        k = (cyc / T) % 4;
        f = cyc % (4 * T);
        act = (c >= G) && se[k];
        ea = act ? ~(4'b0001 << k) : 4'b1111;
        chk("anode", {12'h0, anode}, {12'h0, ea});
        chk("nibble", {12'h0, nibble}, {12'h0, sv[4*k +: 4]});
        chk("dp", {15'h0, dp_out}, {15'h0, act ? ~sd[k] : 1'b1});
        chk("idx", {14'h0, digit_idx}, 16'(k));
        chk("frame", {15'h0, frame}, {15'h0, (f == 4 * T - 1)});
    endtask

    task automatic run_to(input int n);
        while (cyc < n) begin
            chk_cycle();
            tick();
        end
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] e, input logic [3:0] d);
        value = v;
        en = e;
        dp = d;
        load = 1'b1;
        chk_cycle();
        tick();
        load = 1'b0;
    endtask

    task automatic reset_release();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_anode", {12'h0, anode}, 16'h000f);
        chk("rst_nibble", {12'h0, nibble}, 16'h0000);
        chk("rst_dp", {15'h0, dp_out}, 16'h0001);
        chk("rst_idx", {14'h0, digit_idx}, 16'h0000);
        chk("rst_frame", {15'h0, frame}, 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        cyc = 0;
        sv = 16'h0000;
        se = 4'b1111;
        sd = 4'b0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        load = 1'b0;
        reset_release();
    endtask

    initial begin
        // Reset then idle: one full frame of zeros.
        reset_release();
        run_to(32);

        // Deferred load: BEEF at cycle 3 appears only in frame 1.
        do_reset();
        run_to(3);
        pulse_load(16'hBEEF, 4'b1111, 4'b0000);
        run_to(32);
        sv = 16'hBEEF;
        run_to(64);

        // Last load wins within a frame.
        do_reset();
        run_to(5);
        pulse_load(16'h1234, 4'b1111, 4'b0000);
        run_to(20);
        pulse_load(16'h5678, 4'b1111, 4'b0000);
        run_to(32);
        sv = 16'h5678;
        run_to(64);

        // Boundary-cycle load goes straight to the next frame.
        do_reset();
        run_to(31);
        pulse_load(16'hA5C3, 4'b1111, 4'b0000);
        sv = 16'hA5C3;
        chk("pend_after_boundary", {15'h0, dut.pend}, 16'h0000);
        run_to(64);
        chk("pend_end", {15'h0, dut.pend}, 16'h0000);

        // Per-digit enable and decimal point.
        do_reset();
        run_to(3);
        pulse_load(16'h4321, 4'b1011, 4'b0010);
        run_to(32);
        sv = 16'h4321;
        se = 4'b1011;
        sd = 4'b0010;
        run_to(64);

        // Mid-frame reset blanks immediately and restarts the scan.
        do_reset();
        run_to(3);
        pulse_load(16'hFFFF, 4'b1111, 4'b0000);
        run_to(32);
        sv = 16'hFFFF;
        run_to(45);
        chk("pre_rst_anode", {12'h0, anode}, 16'h000d);
        rst = 1'b1;
        #1;
        chk("async_rst_anode", {12'h0, anode}, 16'h000f);
        chk("async_rst_nibble", {12'h0, nibble}, 16'h0000);
        reset_release();
        run_to(32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
